// File: rtl/led_fade_pwm_pkg.sv
// Shared constants and types for the eight-channel LED fade/PWM stage.
package led_pkg;
    localparam int PWM_BITS_DEFAULT = 8;
    localparam int LEVEL_MAX        = (1 << PWM_BITS_DEFAULT) - 1;
    localparam int STEP_DIV_DEFAULT = 50000;

    typedef logic [PWM_BITS_DEFAULT-1:0] level_t;
endpackage

// File: rtl/led_fade_pwm_if.sv
// Pattern load strobe and LED drive/status bundle for led_fade_pwm.
interface led_fade_pwm_if;
    logic [7:0] pattern_in;
    logic       pattern_valid;
    logic [7:0] led;
    logic       busy;

    modport master (output pattern_in, output pattern_valid, input led, input busy);
    modport slave  (input pattern_in, input pattern_valid, output led, output busy);
endinterface

// File: rtl/led_fade_channel.sv
// One LED: saturating brightness ramp toward its target, period-aligned duty shadow, registered PWM output.
module led_fade_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_tick,
    input  logic                period_end,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                target,
    output logic                led,
    output logic                at_target
);
    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

    logic [PWM_BITS-1:0] level_reg;
    logic [PWM_BITS-1:0] level_next;
    logic [PWM_BITS-1:0] duty_reg;
    logic                led_reg;
    logic                led_next;

    always_comb begin
        level_next = level_reg;
        if (step_tick) begin
            if (target && (level_reg != LVL_MAX)) begin
                level_next = level_reg + PWM_BITS'(1);
            end else if (!target && (level_reg != '0)) begin
                level_next = level_reg - PWM_BITS'(1);
            end
        end
    end

    // Full-scale duty must stay solidly on, which the plain compare cannot express.
    assign led_next = (duty_reg == LVL_MAX) || (pwm_cnt < duty_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg <= '0;
            duty_reg  <= '0;
            led_reg   <= 1'b0;
        end else begin
            level_reg <= level_next;
            if (period_end) begin
                duty_reg <= level_reg;
            end
            led_reg <= led_next;
        end
    end

    assign led       = led_reg;
    assign at_target = target ? (level_reg == LVL_MAX) : (level_reg == '0);
endmodule

// File: rtl/led_fade_pwm.sv
// Eight-channel LED fader: target latch, step prescaler, shared PWM counter and busy summary.
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEFAULT,
    parameter int STEP_DIV = STEP_DIV_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    led_fade_pwm_if.slave  bus
);
    localparam int                  STEP_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = '1;

    logic [7:0]          target_reg;
    logic [STEP_W-1:0]   step_cnt_reg;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic                step_tick;
    logic                period_end;
    logic [7:0]          led_bits;
    logic [7:0]          at_target;

    assign step_tick  = (step_cnt_reg == STEP_LAST);
    assign period_end = (pwm_cnt_reg == PWM_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_reg   <= '0;
            step_cnt_reg <= '0;
            pwm_cnt_reg  <= '0;
        end else begin
            if (bus.pattern_valid) begin
                target_reg <= bus.pattern_in;
            end
            step_cnt_reg <= step_tick ? '0 : step_cnt_reg + STEP_W'(1);
            pwm_cnt_reg  <= pwm_cnt_reg + PWM_BITS'(1);
        end
    end

    // Channels see the pre-load target, so a load coinciding with a tick takes effect on the next tick.
    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
        led_fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .step_tick  (step_tick),
            .period_end (period_end),
            .pwm_cnt    (pwm_cnt_reg),
            .target     (target_reg[gi]),
            .led        (led_bits[gi]),
            .at_target  (at_target[gi])
        );
    end

    assign bus.led  = led_bits;
    assign bus.busy = ~&at_target;
endmodule

// File: tb/tb_led_fade_pwm.sv
// Randomized and directed stimulus for led_fade_pwm, scored cycle by cycle against a behavioural model.
module tb_led_fade_pwm;
    import led_pkg::*;

    localparam int STEP_DIV = 4;
    localparam int LMAX     = 255;

    typedef struct {
        logic [7:0] led;
        logic       busy;
    } exp_t;

    logic clk;
    logic rst_n;

    led_fade_pwm_if bus_if ();

    led_fade_pwm #(
        .PWM_BITS (8),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: cycles counted since reset release, per-channel brightness.
    int         m_cycle;
    int         m_level [8];
    int         m_duty  [8];
    logic [7:0] m_target;
    exp_t       exp_q [$];

    int vectors;
    int miscompares;

    task automatic model_reset();
        m_cycle  = 0;
        m_target = '0;
        for (int i = 0; i < 8; i++) begin
            m_level[i] = 0;
            m_duty[i]  = 0;
        end
    endtask

    task automatic model_edge();
        exp_t e;
        int   pwm;
        bit   tick;
        if (!rst_n) begin
            model_reset();
            e.led  = '0;
            e.busy = 1'b0;
            exp_q.push_back(e);
            return;
        end
        pwm  = m_cycle % 256;
        tick = ((m_cycle % STEP_DIV) == STEP_DIV - 1);
        for (int i = 0; i < 8; i++) begin
            e.led[i] = (m_duty[i] == LMAX) || (pwm < m_duty[i]);
            if (pwm == LMAX) m_duty[i] = m_level[i];
            if (tick) begin
                if (m_target[i]) m_level[i] = (m_level[i] < LMAX) ? m_level[i] + 1 : LMAX;
                else             m_level[i] = (m_level[i] > 0) ? m_level[i] - 1 : 0;
            end
        end
        if (bus_if.pattern_valid) m_target = bus_if.pattern_in;
        m_cycle++;
        e.busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_level[i] != (m_target[i] ? LMAX : 0)) e.busy = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic load(input logic [7:0] p);
        bus_if.pattern_in    = p;
        bus_if.pattern_valid = 1'b1;
        cyc();
        bus_if.pattern_valid = 1'b0;
    endtask

    task automatic wait_level0(input int lvl, input int limit);
        for (int k = 0; k < limit && m_level[0] != lvl; k++) cyc();
        if (m_level[0] != lvl) begin
            miscompares++;
            $display("FAIL wait_level0 t=%0t: level[0]=%0d after %0d cycles, required %0d",
                     $time, m_level[0], limit, lvl);
        end
    endtask

    task automatic align_to_tick();
        for (int k = 0; k < STEP_DIV && (m_cycle % STEP_DIV) != STEP_DIV - 1; k++) cyc();
    endtask

    // Dropping reset between edges: the next negedge sample must already show zeros.
    task automatic async_reset(input int hold);
        exp_t e;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        e.led  = '0;
        e.busy = 1'b0;
        exp_q.push_back(e);
        #1;
        vectors++;
        if (bus_if.led !== 8'h00 || bus_if.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset t=%0t: led=%02h busy=%b, required led=00 busy=0",
                     $time, bus_if.led, bus_if.busy);
        end
        for (int k = 0; k < hold; k++) begin
            bus_if.pattern_in    = 8'($urandom);
            bus_if.pattern_valid = 1'($urandom);
            cyc();
        end
        bus_if.pattern_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (bus_if.led !== e.led || bus_if.busy !== e.busy) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t: led=%02h busy=%b, required led=%02h busy=%b",
                         $time, bus_if.led, bus_if.busy, e.led, e.busy);
            end
        end
    end

    initial begin
        vectors              = 0;
        miscompares          = 0;
        rst_n                = 1'b0;
        bus_if.pattern_in    = '0;
        bus_if.pattern_valid = 1'b0;
        model_reset();

        // Inputs toggle while reset is held; outputs must stay cleared.
        for (int k = 0; k < 4; k++) begin
            bus_if.pattern_in    = 8'($urandom);
            bus_if.pattern_valid = 1'b1;
            cyc();
        end
        vectors++;
        if (bus_if.led !== 8'h00 || bus_if.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state t=%0t: led=%02h busy=%b, required led=00 busy=0",
                     $time, bus_if.led, bus_if.busy);
        end
        bus_if.pattern_valid = 1'b0;
        rst_n = 1'b1;
        run(3);

        // Full fade-up of LED 0 and settling.
        load(8'h01);
        run(1100);

        // Reversal at level 100.
        async_reset(2);
        load(8'h01);
        wait_level0(100, 600);
        load(8'h00);
        run(500);

        // Load landing exactly on a step tick, then repeated identical loads.
        load(8'h0F);
        run(41);
        align_to_tick();
        load(8'hF0);
        run(30);
        align_to_tick();
        for (int k = 0; k < 6; k++) load(8'hF0);
        run(40);

        // Random patterns, strobes and hold times.
        for (int it = 0; it < 40; it++) begin
            bus_if.pattern_in    = 8'($urandom);
            bus_if.pattern_valid = 1'($urandom_range(0, 1));
            run($urandom_range(1, 150));
            bus_if.pattern_valid = 1'b0;
            run($urandom_range(0, 50));
        end

        // Reset mid-fade at level 150, then restart from zero.
        async_reset(2);
        load(8'hFF);
        wait_level0(150, 1000);
        async_reset(3);
        load(8'hA5);
        run(400);

        run(2);
        #6;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
